// File: rtl/lsu_mem_port.sv
// ============================================================================
// lsu_mem_port : byte/half/word load-store initiator onto a word-wide data RAM,
//                with byte-lane merging and two-access split for spanning requests.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_port #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [1:0]          off_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         ld_q, ld_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         ld_ext;
  logic [31:0]         wr_word;
  logic [2:0]          nbytes;
  logic                span;
  logic                accessing;
  logic                in_acc1;
  logic [2:0]          lane_k;
  logic                lane_hit;

  assign nbytes    = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
  assign span      = ({1'b0, off_q} + nbytes) > 3'd4;
  assign accessing = (state_q == ACC0) || (state_q == ACC1);
  assign in_acc1   = (state_q == ACC1);

  assign req_ready      = (state_q == IDLE) && rst_n;
  assign resp_valid     = (state_q == RESP) && rst_n;
  // Gated by rst_n so a reset during an access never commits that access.
  assign mem_w_en       = accessing && we_q && rst_n;
  assign mem_write_data = mem_w_en ? wr_word : 32'd0;
  assign mem_address    = addr_q;
  assign resp_rdata     = rdata_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ld_d     = ld_q;
    rdata_d  = rdata_q;
    wr_word  = mem_read_data;
    lane_k   = 3'd0;
    lane_hit = 1'b0;
    ld_ext   = 32'd0;

    if (state_q == IDLE) begin
      ld_d = 32'd0;
    end

    // lane_k is the request byte index that lands in RAM lane l this access.
    if (accessing) begin
      for (int l = 0; l < 4; l++) begin
        lane_k   = in_acc1 ? (3'(l) + 3'd4 - {1'b0, off_q}) : (3'(l) - {1'b0, off_q});
        lane_hit = (in_acc1 || (3'(l) >= {1'b0, off_q})) && (lane_k < nbytes);
        if (lane_hit) begin
          wr_word[8*l +: 8]                   = wdata_q[{lane_k[1:0], 3'b000} +: 8];
          ld_d[{lane_k[1:0], 3'b000} +: 8]    = mem_read_data[8*l +: 8];
        end
      end
    end

    case (size_q)
      2'd0:    ld_ext = {{24{signed_q & ld_d[7]}}, ld_d[7:0]};
      2'd1:    ld_ext = {{16{signed_q & ld_d[15]}}, ld_d[15:0]};
      default: ld_ext = ld_d;
    endcase

    if (((state_q == ACC0) && !span) || in_acc1) begin
      rdata_d = we_q ? 32'd0 : ld_ext;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACC0;
          addr_d  = req_addr[ADDR_W+1:2];
        end
      end
      ACC0: begin
        if (span) begin
          state_d = ACC1;
          addr_d  = addr_q + ADDR_W'(1);
        end else begin
          state_d = RESP;
        end
      end
      ACC1:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      off_q    <= 2'd0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
      addr_q   <= '0;
      ld_q     <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
      rdata_q <= rdata_d;
      if ((state_q == IDLE) && req_valid) begin
        we_q     <= req_we;
        off_q    <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

`default_nettype wire
